bit_index_sequencer: RTL and testbench
======================================

# bit_index_sequencer

Upstream feeder for `decoder_3to8` in the bit-serial datapath. Accepts 8-bit operand words over a valid/ready handshake and emits, one per cycle, the 3-bit position index of each set bit, most significant first. Each index drives `decoder_3to8`, which turns it back into a one-hot bit select, so zero bits cost no cycles. A sideband tag travels with every beat, and the last index of each word is flagged.

## Interface
- TAG_W, 4, width of the sideband tag carried from input word to each output beat
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_val  in  1  input word valid
- in_rdy  out  1  block can accept a word this cycle
- in_word  in  8  operand word; bit 7 = MSB
- in_tag  in  TAG_W  sideband tag for the word
- out_val  out  1  output beat valid
- out_rdy  in  1  downstream accepts beat
- out_idx  out  3  bit position index, encoded as 7 − bit number (idx 0 = bit 7, idx 7 = bit 0), matching `decoder_3to8`
- out_last  out  1  beat is the final beat of its word
- out_zero  out  1  beat represents an all-zero word (no real index)
- out_tag  out  TAG_W  tag of the word the beat belongs to
- busy  out  1  a word is held (state EMIT)

## Operation
- Two states:
  - IDLE: no word held.
  - EMIT: word held in remaining-bit mask `rem[7:0]`, with `tag_q` and `zero_q` registers.
- `in_rdy` = IDLE, or (EMIT && out_last && out_rdy). This allows a next word to load on the same edge that the current word's final beat is taken.
- Word accept = in_val && in_rdy.
  - Nonzero word: rem ← in_word, tag_q ← in_tag, zero_q ← 0, go EMIT.
  - Zero word: see Configuration.
- In EMIT, outputs are combinational from registered state:
  - out_val = 1.
  - out_idx = 7 − (position of highest set bit of rem).
  - out_last = 1 if popcount(rem) == 1 or zero_q.
  - out_tag = tag_q; out_zero = zero_q.
- Beat taken (out_val && out_rdy):
  - Clear the highest set bit of rem.
  - If out_last: load a new word if one is accepted that cycle, else go IDLE.
- Stall (out_val && !out_rdy): rem, tag_q, zero_q and all outputs hold stable; no input is accepted.
- In IDLE: out_val = 0, and out_idx, out_last, out_zero, out_tag all = 0.
- Reset: state IDLE, rem = 0, tag_q = 0, zero_q = 0. All outputs are 0, including in_rdy and busy; in_rdy rises in the first cycle after reset deasserts.
- Reset mid-word: the remaining indices are discarded with no further beats. Reset dominates a simultaneous accept.

## Timing
- Latency: word accepted on edge N → first beat valid in cycle N+1.
- Throughput: one index per cycle with out_rdy held high. Consecutive words run with no bubble: the last beat of word k is followed by the first beat of word k+1 in the next cycle.
- A word with p set bits occupies exactly p beats. An all-zero word occupies 1 beat when ZERO_SKIP_EN is not defined, and 0 beats when it is.
- Handshakes are standard valid/ready:
  - out_val does not depend on out_rdy.
  - in_rdy depends combinationally on out_rdy only through the last-beat term.

## Configuration
- Macro: `BIT_INDEX_SEQUENCER_ZERO_SKIP_EN`.
- Not defined: an accepted zero word enters EMIT with zero_q = 1 and emits exactly one beat: out_idx = 0, out_zero = 1, out_last = 1, out_tag = its tag. Downstream must gate the decoder output with out_zero.
- Defined: an accepted zero word is consumed and dropped; it produces no beat, and state/rem are unchanged by it.
  - If accepted in IDLE: remain IDLE.
  - If accepted on a last beat: go IDLE.
  - out_zero is tied to 0.

## Test plan
- in_word = 0xA5, tag 3, out_rdy = 1 → out_idx 0, 2, 5, 7 on four consecutive cycles, all with tag 3; out_last only on idx 7; then IDLE.
- in_word = 0xFF with out_rdy toggling 1,0,0,1,… → indices 0..7 in order with no loss or duplication; outputs stable during stalls; in_rdy = 0 until the last beat is taken.
- in_word 0x01 (tag 1) then 0x80 (tag 2) presented back-to-back → idx 7 with last and tag 1, then next cycle idx 0 with last and tag 2; in_rdy = 1 on the idx-7 cycle.
- in_word = 0x00, tag 5 → without the macro: one beat (idx 0, out_zero = 1, out_last = 1, tag 5). With the macro: no beat, and in_rdy stays 1.
- Reset after 2 beats of 0xF0 → the next cycle shows out_val = 0, busy = 0, in_rdy = 0; in_rdy = 1 the cycle after reset drops; a following 0x10 yields a single beat, idx 3 with last.

Source files
------------

// File: rtl/bit_index_sequencer.sv
// bit_index_sequencer
// Accepts 8-bit operand words over valid/ready and emits, one per cycle, the
// 3-bit index (7 - bit number) of every set bit, MSB first, for decoder_3to8.
// A sideband tag rides with each beat; the final beat of a word is flagged.
//
// Optional build macro: BIT_INDEX_SEQUENCER_ZERO_SKIP_EN
//   undefined : an all-zero word emits one beat with out_zero = 1
//   defined   : an all-zero word is consumed silently, out_zero tied to 0
module bit_index_sequencer #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [7:0]       in_word,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [2:0]       out_idx,
    output logic             out_last,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t           state;
    logic [7:0]       rem;      // bits of the held word not yet emitted
    logic [TAG_W-1:0] tag_q;
    logic             zero_q;   // held word is an all-zero word
    logic             run_q;    // low for the cycle(s) under reset, keeps in_rdy at 0

    logic [2:0]       hi_idx;
    logic             single;
    logic [7:0]       clr_mask;
    logic             take;
    logic             take_last;
    logic             accept;

    // Locate the highest set bit of rem and decode all handshake outputs.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update so
        // no path leaves it unassigned and no latch is inferred.
        hi_idx = 3'd0;
        // Ascending scan: the last hit wins, i.e. the most significant set bit.
        for (int i = 0; i < 8; i++) begin
            if (rem[i]) begin
                hi_idx = 3'(7 - i);
            end
        end
        single   = (rem != 8'd0) && ((rem & (rem - 8'd1)) == 8'd0);
        clr_mask = 8'h80 >> hi_idx;

        busy     = (state == EMIT);
        out_val  = busy;
        out_idx  = busy ? hi_idx : 3'd0;
        out_last = busy && (single || zero_q);
`ifdef BIT_INDEX_SEQUENCER_ZERO_SKIP_EN
        out_zero = 1'b0;
`else
        out_zero = busy && zero_q;
`endif
        out_tag  = busy ? tag_q : '0;

        take      = out_val && out_rdy;
        take_last = take && out_last;
        // A new word may load on the same edge the final beat is taken.
        in_rdy    = ((state == IDLE) && run_q) || take_last;
        accept    = in_val && in_rdy;
    end

    // Sequencer state: retire beats, load accepted words, reset dominates.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state  <= IDLE;
            rem    <= 8'd0;
            tag_q  <= '0;
            zero_q <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            run_q <= 1'b1;

            if (take) begin
                rem <= rem & ~clr_mask;
                if (out_last) begin
                    state  <= IDLE;
                    zero_q <= 1'b0;
                end
            end

            // Later assignments override the retire step when a word loads.
            if (accept) begin
                if (in_word != 8'd0) begin
                    rem    <= in_word;
                    tag_q  <= in_tag;
                    zero_q <= 1'b0;
                    state  <= EMIT;
                end else begin
`ifdef BIT_INDEX_SEQUENCER_ZERO_SKIP_EN
                    // Zero word is dropped: no beat, nothing held.
                    state <= IDLE;
`else
                    // Zero word becomes a single flagged beat.
                    rem    <= 8'd0;
                    tag_q  <= in_tag;
                    zero_q <= 1'b1;
                    state  <= EMIT;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_index_sequencer.sv
// Scoreboard bench for bit_index_sequencer: stimulus pushes expected beats,
// a negedge monitor pops and compares each beat taken by the downstream.
module tb_bit_index_sequencer;

    localparam int TAG_W = 4;

    typedef struct packed {
        logic [2:0]       idx;
        logic             last;
        logic             zero;
        logic [TAG_W-1:0] tag;
    } beat_t;

    logic             clk;
    logic             reset;
    logic             in_val;
    logic             in_rdy;
    logic [7:0]       in_word;
    logic [TAG_W-1:0] in_tag;
    logic             out_val;
    logic             out_rdy;
    logic [2:0]       out_idx;
    logic             out_last;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    beat_t exp_q[$];
    int    beat_cyc[$];
    beat_t prev;
    logic  prev_stall = 1'b0;

    bit_index_sequencer #(.TAG_W(TAG_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_word  (in_word),
        .in_tag   (in_tag),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_idx  (out_idx),
        .out_last (out_last),
        .out_zero (out_zero),
        .out_tag  (out_tag),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d beats outstanding", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare taken beats against the scoreboard, check stall rules.
    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {out_val, out_idx, out_last, out_zero, out_tag}, {1'b1, prev});
            if (out_val && !out_last)
                check("mid_word_in_rdy", in_rdy, 0);
            if (out_val && !out_rdy)
                check("stall_in_rdy", in_rdy, 0);
            if (out_val && out_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got idx=%0d last=%0d zero=%0d tag=%0d expected no beat",
                             out_idx, out_last, out_zero, out_tag);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {out_idx, out_last, out_zero, out_tag}, e);
                end
                beat_cyc.push_back(cyc);
            end
            prev_stall = out_val && !out_rdy;
            prev       = {out_idx, out_last, out_zero, out_tag};
        end
    end

    // Reference model: one beat per set bit, MSB first; zero word per build.
    task automatic push_expect(input logic [7:0] w, input logic [TAG_W-1:0] t);
        int n_left;
        n_left = $countones(w);
        for (int i = 0; i < 8; i++) begin
            if (w[7-i]) begin
                n_left--;
                exp_q.push_back({3'(i), n_left == 0, 1'b0, t});
            end
        end
`ifndef BIT_INDEX_SEQUENCER_ZERO_SKIP_EN
        if (w == 8'd0)
            exp_q.push_back({3'd0, 1'b1, 1'b1, t});
`endif
    endtask

    // Present a word until accepted; returns the number of cycles presented.
    task automatic send_word(input logic [7:0] w, input logic [TAG_W-1:0] t,
                             input bit push, output int waited);
        logic ok;
        if (push) push_expect(w, t);
        in_val  = 1'b1;
        in_word = w;
        in_tag  = t;
        waited  = 0;
        ok      = 1'b0;
        while (!ok && waited < 50) begin
            @(negedge clk);
            ok = in_rdy;
            waited++;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: word 0x%0h not accepted after %0d cycles", w, waited);
        end
        in_val  = 1'b0;
        in_word = 8'd0;
        in_tag  = '0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_idle"}, busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        logic [3:0] pat;
        reset   = 1'b1;
        in_val  = 1'b0;
        in_word = 8'd0;
        in_tag  = '0;
        out_rdy = 1'b1;

        // Reset state: everything low, including in_rdy.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {out_val, in_rdy, busy, out_idx, out_last, out_zero, out_tag}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_release_in_rdy_low", in_rdy, 0);
        @(negedge clk);
        check("rst_release_in_rdy_high", in_rdy, 1);
        @(posedge clk);
        #1;

        // 0xA5 tag 3: idx 0,2,5,7 on four consecutive cycles.
        beat_cyc.delete();
        send_word(8'hA5, 4'd3, 1'b1, w);
        drain("a5");
        check("a5_beats", beat_cyc.size(), 4);
        if (beat_cyc.size() == 4)
            check("a5_span", beat_cyc[3] - beat_cyc[0], 3);

        // 0xFF with out_rdy pattern 1,0,0,1: no loss, stable stalls.
        beat_cyc.delete();
        pat = 4'b1001;
        fork
            send_word(8'hFF, 4'd4, 1'b1, w);
            begin
                for (int k = 0; k < 40; k++) begin
                    out_rdy = pat[k % 4];
                    @(posedge clk);
                    #1;
                end
                out_rdy = 1'b1;
            end
        join
        drain("ff");
        check("ff_beats", beat_cyc.size(), 8);

        // 0x01 tag 1 then 0x80 tag 2 back to back: no bubble.
        beat_cyc.delete();
        send_word(8'h01, 4'd1, 1'b1, w);
        send_word(8'h80, 4'd2, 1'b1, w);
        check("b2b_in_rdy_on_last", w, 1);
        drain("b2b");
        check("b2b_beats", beat_cyc.size(), 2);
        if (beat_cyc.size() == 2)
            check("b2b_gap", beat_cyc[1] - beat_cyc[0], 1);

        // Zero word tag 5.
        beat_cyc.delete();
        send_word(8'h00, 4'd5, 1'b1, w);
`ifdef BIT_INDEX_SEQUENCER_ZERO_SKIP_EN
        @(negedge clk);
        check("zero_in_rdy", in_rdy, 1);
        check("zero_no_val", out_val, 0);
        drain("zero");
        check("zero_beats", beat_cyc.size(), 0);
`else
        drain("zero");
        check("zero_beats", beat_cyc.size(), 1);
`endif

        // Reset after two beats of 0xF0, then 0x10 tag 9.
        send_word(8'hF0, 4'd6, 1'b0, w);
        exp_q.push_back({3'd0, 1'b0, 1'b0, 4'd6});
        exp_q.push_back({3'd1, 1'b0, 1'b0, 4'd6});
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_out_val", out_val, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_rdy_low", in_rdy, 0);
        check("midrst_two_beats", exp_q.size(), 0);
        @(negedge clk);
        check("midrst_in_rdy_high", in_rdy, 1);
        @(posedge clk);
        #1;
        beat_cyc.delete();
        send_word(8'h10, 4'd9, 1'b1, w);
        drain("post_rst");
        check("post_rst_beats", beat_cyc.size(), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
